// File: rtl/ifetch_pkg.sv
// Shared types and AXI constants for the instruction-fetch front end.
package ifetch_pkg;

   typedef enum logic [2:0] {IDLE, AR, R, DRAIN, HALT} fetch_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
   localparam logic [2:0] AXI_PROT_INSN  = 3'b100;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] bits;
      logic        err;
   } inst_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Two-write, one-read instruction FIFO with flush, free-entry count and a head
// taken straight from the storage registers (no write-to-read bypass).
module inst_queue
   import ifetch_pkg::*;
#(
   parameter int unsigned QDEPTH = 32,
   localparam int unsigned AW = $clog2(QDEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          we0,
   input  inst_entry_t   wd0,
   input  logic          we1,
   input  inst_entry_t   wd1,
   input  logic          deq,
   output logic          head_valid,
   output inst_entry_t   head,
   output logic [CW-1:0] free
);

   inst_entry_t   mem_q [QDEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] idx1;
   logic [CW-1:0] n_wr;
   logic          do_deq;

   assign head       = mem_q[rd_ptr_q];
   assign head_valid = (count_q != '0) && !flush;
   assign do_deq     = head_valid && deq;
   // A lone high-word write lands in the slot a low-word write would have used.
   assign idx1       = wr_ptr_q + AW'(we0);
   assign n_wr       = CW'(we0) + CW'(we1);
   assign free       = CW'(QDEPTH) - count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + AW'(do_deq);
         wr_ptr_d = wr_ptr_q + AW'(n_wr);
         count_d  = count_q + n_wr - CW'(do_deq);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we0 && !flush) mem_q[wr_ptr_q] <= wd0;
      if (we1 && !flush) mem_q[idx1] <= wd1;
   end

endmodule

// File: rtl/ifetch_axi_queue.sv
// Instruction-fetch front end: AXI4 line bursts split into PC-tagged words for decode.
// Define IFETCH_TRACE_EN to print each delivered instruction and entry to HALT.
module ifetch_axi_queue
   import ifetch_pkg::*;
#(
   parameter int unsigned ID_WIDTH   = 13,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned QDEPTH     = 32,
   parameter int unsigned FETCH_ID   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [63:0]           entry,
   input  logic                  redirect_valid,
   input  logic [63:0]           redirect_pc,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [63:0]           inst_pc,
   output logic [31:0]           inst_bits,
   output logic                  inst_err,
   output logic                  halted
);

   localparam int unsigned QCntW     = $clog2(QDEPTH) + 1;
   localparam logic [63:0] LineBytes = 64'(BURST_LEN * 8);
   localparam logic [63:0] LineMask  = ~(LineBytes - 64'd1);

   fetch_state_t     state_q, state_d;
   logic [63:0]      fetch_pc_q, fetch_pc_d;
   logic [63:0]      araddr_q, araddr_d;
   logic [63:0]      beat_addr_q, beat_addr_d;
   logic             stop_q, stop_d;
   logic             drain_pend_q, drain_pend_d;
   logic [63:0]      redir_pc, lo_pc, hi_pc;
   logic             lo_elig, hi_elig, lo_halt, hi_halt, beat_err;
   logic             we0, we1;
   inst_entry_t      wd0, wd1, head;
   logic [QCntW-1:0] q_free;
   logic             q_empty;
   logic             unused_in;

   assign unused_in = ^{m_axi_rid, redirect_pc[1:0], entry[1:0]};

   assign m_axi_arid    = ID_WIDTH'(FETCH_ID);
   assign m_axi_araddr  = araddr_q[ADDR_WIDTH-1:0];
   assign m_axi_arlen   = 8'(BURST_LEN - 1);
   assign m_axi_arsize  = AXI_SIZE_8B;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0000;
   assign m_axi_arprot  = AXI_PROT_INSN;
   assign m_axi_arvalid = (state_q == AR);
   assign m_axi_rready  = (state_q == R) || (state_q == DRAIN);

   assign redir_pc = {redirect_pc[63:2], 2'b00};
   assign lo_pc    = beat_addr_q;
   assign hi_pc    = beat_addr_q + 64'd4;
   assign beat_err = (m_axi_rresp != 2'b00);
   // Once a halt word or error has been seen, the rest of the burst is only drained.
   assign lo_elig  = !stop_q && (lo_pc >= fetch_pc_q);
   assign hi_elig  = !stop_q && (hi_pc >= fetch_pc_q);
   assign lo_halt  = lo_elig && !beat_err && (m_axi_rdata[31:0] == 32'h0);
   assign hi_halt  = hi_elig && !beat_err && !lo_halt && (m_axi_rdata[63:32] == 32'h0);

   assign wd0 = '{pc: lo_pc, bits: m_axi_rdata[31:0], err: beat_err};
   assign wd1 = '{pc: hi_pc, bits: m_axi_rdata[63:32], err: beat_err};

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      araddr_d     = araddr_q;
      beat_addr_d  = beat_addr_q;
      stop_d       = stop_q;
      drain_pend_d = drain_pend_q;
      we0          = 1'b0;
      we1          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               fetch_pc_d = redir_pc;
            end else if (q_free >= QCntW'(2 * BURST_LEN)) begin
               state_d  = AR;
               araddr_d = fetch_pc_q & LineMask;
            end
         end
         AR: begin
            if (redirect_valid) begin
               fetch_pc_d   = redir_pc;
               drain_pend_d = 1'b1;
            end
            if (m_axi_arready) begin
               beat_addr_d  = araddr_q;
               stop_d       = 1'b0;
               drain_pend_d = 1'b0;
               state_d      = (drain_pend_q || redirect_valid) ? DRAIN : R;
            end
         end
         R: begin
            if (redirect_valid) begin
               fetch_pc_d = redir_pc;
               state_d    = (m_axi_rvalid && m_axi_rlast) ? IDLE : DRAIN;
            end else if (m_axi_rvalid) begin
               beat_addr_d = beat_addr_q + 64'd8;
               we0         = lo_elig && !lo_halt;
               we1         = hi_elig && !lo_halt && !hi_halt;
               if (beat_err || lo_halt || hi_halt) stop_d = 1'b1;
               if (m_axi_rlast) begin
                  fetch_pc_d = araddr_q + LineBytes;
                  state_d    = stop_d ? HALT : IDLE;
               end
            end
         end
         DRAIN: begin
            if (redirect_valid) fetch_pc_d = redir_pc;
            if (m_axi_rvalid && m_axi_rlast) state_d = IDLE;
         end
         HALT: begin
            if (redirect_valid) begin
               fetch_pc_d = redir_pc;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         fetch_pc_q   <= {entry[63:2], 2'b00};
         araddr_q     <= '0;
         beat_addr_q  <= '0;
         stop_q       <= 1'b0;
         drain_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         araddr_q     <= araddr_d;
         beat_addr_q  <= beat_addr_d;
         stop_q       <= stop_d;
         drain_pend_q <= drain_pend_d;
      end
   end

   inst_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .we0        (we0),
      .wd0        (wd0),
      .we1        (we1),
      .wd1        (wd1),
      .deq        (inst_ready),
      .head_valid (inst_valid),
      .head       (head),
      .free       (q_free)
   );

   assign inst_pc   = head.pc;
   assign inst_bits = head.bits;
   assign inst_err  = head.err;
   assign q_empty   = (q_free == QCntW'(QDEPTH));
   assign halted    = (state_q == HALT) && q_empty;

`ifdef IFETCH_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && inst_valid && inst_ready) $display("%h: %h", inst_pc, inst_bits);
      if (!reset && state_q != HALT && state_d == HALT)
         $display("ifetch: fetch stopped, next pc %h", fetch_pc_d);
   end
`else
   // Silent build: no trace output.
`endif

endmodule

// File: tb/tb_ifetch_axi_queue.sv
// Randomized bench for ifetch_axi_queue: AXI slave over a synthetic program image,
// expected instruction stream derived directly from the program order rules.
module tb_ifetch_axi_queue;
   import ifetch_pkg::*;

   localparam int unsigned BL = 8;

   logic        clk = 1'b0;
   logic        reset, redirect_valid, inst_ready;
   logic [63:0] entry, redirect_pc;
   logic [12:0] m_axi_arid, m_axi_rid;
   logic [63:0] m_axi_araddr, m_axi_rdata, inst_pc;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize, m_axi_arprot;
   logic [1:0]  m_axi_arburst, m_axi_rresp;
   logic [3:0]  m_axi_arcache;
   logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic        inst_valid, inst_err, halted;
   logic [31:0] inst_bits;

   always #5 clk = ~clk;

   ifetch_axi_queue #(
      .ID_WIDTH (13), .ADDR_WIDTH (64), .DATA_WIDTH (64),
      .BURST_LEN (BL), .QDEPTH (32), .FETCH_ID (0)
   ) dut (
      .clk (clk), .reset (reset), .entry (entry),
      .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
      .m_axi_arid (m_axi_arid), .m_axi_araddr (m_axi_araddr), .m_axi_arlen (m_axi_arlen),
      .m_axi_arsize (m_axi_arsize), .m_axi_arburst (m_axi_arburst),
      .m_axi_arlock (m_axi_arlock), .m_axi_arcache (m_axi_arcache),
      .m_axi_arprot (m_axi_arprot), .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready), .m_axi_rid (m_axi_rid), .m_axi_rdata (m_axi_rdata),
      .m_axi_rresp (m_axi_rresp), .m_axi_rlast (m_axi_rlast), .m_axi_rvalid (m_axi_rvalid),
      .m_axi_rready (m_axi_rready), .inst_valid (inst_valid), .inst_ready (inst_ready),
      .inst_pc (inst_pc), .inst_bits (inst_bits), .inst_err (inst_err), .halted (halted)
   );

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Program image: nonzero everywhere except zero_addr; err_beat returns SLVERR.
   logic [63:0] zero_addr = '1;
   logic [63:0] err_beat  = '1;
   logic [31:0] salt      = 32'h1234_5678;
   int unsigned ar_pct = 100, r_pct = 100, rdy_pct = 100;

   logic [63:0] ar_pend[$];
   logic [63:0] ar_log[$];
   logic [15:0] ar_fields;
   int unsigned r_beat = 0, beats_acc = 0;
   inst_entry_t got_q[$];
   inst_entry_t exp_q[$];

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == zero_addr) return 32'h0;
      return ((a[31:0] * 32'h9E37_79B1) ^ salt) | 32'h1;
   endfunction

   // Sequential program order from pc: stop before a zero word; an error beat
   // delivers its remaining words flagged and ends the stream.
   function automatic void build_exp(input logic [63:0] pc, input int max_n);
      logic [63:0] a = pc;
      inst_entry_t e;
      exp_q.delete();
      while (exp_q.size() < max_n) begin
         if ((a & ~64'h7) == err_beat) begin
            e.pc = a; e.bits = mem_word(a); e.err = 1'b1;
            exp_q.push_back(e);
            if (a[2] == 1'b0) begin
               e.pc = a + 64'd4; e.bits = mem_word(a + 64'd4);
               exp_q.push_back(e);
            end
            break;
         end
         if (mem_word(a) == 32'h0) break;
         e.pc = a; e.bits = mem_word(a); e.err = 1'b0;
         exp_q.push_back(e);
         a = a + 64'd4;
      end
   endfunction

   function automatic int first_diff();
      for (int i = 0; i < got_q.size(); i++)
         if (i >= exp_q.size() || got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   function automatic logic [63:0] ar_at(input int i);
      return (i < ar_log.size()) ? ar_log[i] : '1;
   endfunction

   function automatic inst_entry_t got_at(input int i);
      return (i >= 0 && i < got_q.size()) ? got_q[i] : '1;
   endfunction

   function automatic inst_entry_t exp_at(input int i);
      return (i >= 0 && i < exp_q.size()) ? exp_q[i] : '1;
   endfunction

   task automatic step(input logic redir, input logic [63:0] rpc);
      inst_entry_t e;
      logic [63:0] ba;
      @(negedge clk);
      redirect_valid = redir;
      redirect_pc    = rpc;
      m_axi_arready  = ($urandom_range(99) < ar_pct);
      inst_ready     = ($urandom_range(99) < rdy_pct);
      m_axi_rid      = 13'($urandom);
      if (ar_pend.size() != 0) begin
         ba           = ar_pend[0] + 64'(r_beat * 8);
         m_axi_rvalid = ($urandom_range(99) < r_pct);
         m_axi_rdata  = {mem_word(ba + 64'd4), mem_word(ba)};
         m_axi_rresp  = (ba == err_beat) ? 2'b10 : 2'b00;
         m_axi_rlast  = (r_beat == BL - 1);
      end else begin
         m_axi_rvalid = 1'b0;
         m_axi_rdata  = {$urandom, $urandom};
         m_axi_rresp  = 2'b00;
         m_axi_rlast  = 1'b0;
      end
      #1;
      if (m_axi_arvalid && m_axi_arready) begin
         ar_log.push_back(m_axi_araddr);
         ar_pend.push_back(m_axi_araddr);
         ar_fields = {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot};
      end
      if (m_axi_rvalid && m_axi_rready) begin
         beats_acc++;
         r_beat++;
         if (r_beat == BL) begin
            r_beat = 0;
            void'(ar_pend.pop_front());
         end
      end
      if (inst_valid && inst_ready) begin
         e.pc = inst_pc; e.bits = inst_bits; e.err = inst_err;
         got_q.push_back(e);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 64'd0);
   endtask

   task automatic do_reset(input logic [63:0] e);
      @(negedge clk);
      reset = 1'b1; entry = e; redirect_valid = 1'b0; inst_ready = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      ar_pend.delete(); ar_log.delete(); got_q.delete();
      r_beat = 0; beats_acc = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic set_knobs(input int unsigned a, input int unsigned r, input int unsigned d);
      ar_pct = a; r_pct = r; rdy_pct = d;
   endtask

   task automatic test_reset();
      logic [63:0] e = {$urandom, $urandom} | 64'h3;
      zero_addr = '1; err_beat = '1;
      set_knobs(100, 100, 0);
      do_reset(64'h0);
      @(negedge clk);
      reset = 1'b1; entry = e;
      @(negedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if ({m_axi_arvalid, m_axi_rready, inst_valid, halted} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: arvalid/rready/inst_valid/halted = %b, want 0000",
                  {m_axi_arvalid, m_axi_rready, inst_valid, halted});
      end
      vectors++;
      if (m_axi_araddr !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_araddr: got %h want 0", m_axi_araddr);
      end
      vectors++;
      if ({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
           m_axi_arprot} !== {13'd0, 8'd7, 3'd3, 2'b01, 1'b0, 4'd0, 3'b100}) begin
         miscompares++;
         $display("FAIL reset_ar_const: id %h len %h size %h burst %b lock %b cache %h prot %b",
                  m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                  m_axi_arcache, m_axi_arprot);
      end
      @(negedge clk);
      reset = 1'b0;
      run(6);
      vectors++;
      if (ar_at(0) !== (e & ~64'h3F)) begin
         miscompares++;
         $display("FAIL reset_entry_ar: got %h want %h", ar_at(0), e & ~64'h3F);
      end
   endtask

   task automatic test_linear();
      int d;
      zero_addr = '1; err_beat = '1;
      set_knobs(100, 100, 100);
      do_reset(64'h1000);
      run(60);
      build_exp(64'h1000, 100);
      vectors++;
      if (ar_at(0) !== 64'h1000 || ar_at(1) !== 64'h1040) begin
         miscompares++;
         $display("FAIL linear_ar: got %h,%h want 1000,1040", ar_at(0), ar_at(1));
      end
      vectors++;
      if (ar_fields !== {8'd7, 3'd3, 2'b01, 3'b100}) begin
         miscompares++;
         $display("FAIL linear_ar_fields: got %h want %h", ar_fields,
                  {8'd7, 3'd3, 2'b01, 3'b100});
      end
      d = first_diff();
      vectors++;
      if (d >= 0 || got_q.size() < 16) begin
         miscompares++;
         $display("FAIL linear_stream: n=%0d idx %0d got pc %h bits %h want pc %h bits %h",
                  got_q.size(), d, got_at(d).pc, got_at(d).bits, exp_at(d).pc, exp_at(d).bits);
      end
   endtask

   task automatic test_mid_line();
      int d, n_line;
      zero_addr = '1; err_beat = '1;
      set_knobs(100, 100, 100);
      do_reset(64'h1014);
      run(40);
      build_exp(64'h1014, 100);
      n_line = 0;
      foreach (got_q[i]) if (got_q[i].pc < 64'h1040) n_line++;
      vectors++;
      if (ar_at(0) !== 64'h1000) begin
         miscompares++;
         $display("FAIL midline_ar: got %h want 1000", ar_at(0));
      end
      vectors++;
      if (n_line != 11 || got_at(0).pc !== 64'h1014) begin
         miscompares++;
         $display("FAIL midline_count: got %0d first pc %h want 11 first 1014",
                  n_line, got_at(0).pc);
      end
      d = first_diff();
      vectors++;
      if (d >= 0) begin
         miscompares++;
         $display("FAIL midline_stream: idx %0d got pc %h want pc %h",
                  d, got_at(d).pc, exp_at(d).pc);
      end
   endtask

   task automatic test_backpressure();
      int d;
      zero_addr = '1; err_beat = '1;
      set_knobs(100, 100, 0);
      do_reset(64'h1000);
      run(60);
      vectors++;
      if (ar_log.size() != 2 || ar_at(1) !== 64'h1040 || !inst_valid || inst_pc !== 64'h1000)
      begin
         miscompares++;
         $display("FAIL bp_full: ars %0d ar1 %h valid %b pc %h want 2 1040 1 1000",
                  ar_log.size(), ar_at(1), inst_valid, inst_pc);
      end
      set_knobs(100, 100, 100);
      run(1);
      set_knobs(100, 100, 0);
      run(30);
      vectors++;
      if (ar_log.size() != 2) begin
         miscompares++;
         $display("FAIL bp_one_deq: got %0d ARs want 2", ar_log.size());
      end
      set_knobs(100, 100, 100);
      run(15);
      set_knobs(100, 100, 0);
      run(10);
      vectors++;
      if (ar_log.size() != 3 || ar_at(2) !== 64'h1080) begin
         miscompares++;
         $display("FAIL bp_rearm: got %0d ARs third %h want 3 1080", ar_log.size(), ar_at(2));
      end
      build_exp(64'h1000, 100);
      d = first_diff();
      vectors++;
      if (d >= 0 || got_q.size() != 16) begin
         miscompares++;
         $display("FAIL bp_stream: n=%0d idx %0d got pc %h want pc %h",
                  got_q.size(), d, got_at(d).pc, exp_at(d).pc);
      end
   endtask

   task automatic test_halt();
      int d;
      zero_addr = 64'h1018; err_beat = '1;
      set_knobs(70, 70, 0);
      do_reset(64'h1000);
      run(60);
      vectors++;
      if ({halted, inst_valid} !== 2'b01 || beats_acc != 8) begin
         miscompares++;
         $display("FAIL halt_pending: halted %b valid %b beats %0d want 0 1 8",
                  halted, inst_valid, beats_acc);
      end
      set_knobs(70, 70, 100);
      run(30);
      build_exp(64'h1000, 100);
      d = first_diff();
      vectors++;
      if (d >= 0 || got_q.size() != exp_q.size() || exp_q.size() != 6) begin
         miscompares++;
         $display("FAIL halt_stream: n=%0d idx %0d got pc %h want pc %h (6 words)",
                  got_q.size(), d, got_at(d).pc, exp_at(d).pc);
      end
      vectors++;
      if (halted !== 1'b1 || ar_log.size() != 1) begin
         miscompares++;
         $display("FAIL halt_state: halted %b ars %0d want 1 1", halted, ar_log.size());
      end
   endtask

   task automatic test_redirect();
      int d, guard;
      zero_addr = '1; err_beat = '1;
      set_knobs(100, 100, 100);
      do_reset(64'h1000);
      guard = 0;
      while (beats_acc < 4 && guard < 60) begin
         run(1);
         guard++;
      end
      build_exp(64'h1000, 100);
      d = first_diff();
      vectors++;
      if (beats_acc != 4 || d >= 0) begin
         miscompares++;
         $display("FAIL redir_pre: beats %0d idx %0d got pc %h want pc %h",
                  beats_acc, d, got_at(d).pc, exp_at(d).pc);
      end
      got_q.delete();
      ar_log.delete();
      step(1'b1, 64'h2003);
      @(posedge clk);
      #1;
      vectors++;
      if (inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redir_flush: inst_valid %b want 0", inst_valid);
      end
      run(60);
      build_exp(64'h2000, 100);
      d = first_diff();
      vectors++;
      if (ar_at(0) !== 64'h2000) begin
         miscompares++;
         $display("FAIL redir_ar: got %h want 2000", ar_at(0));
      end
      vectors++;
      if (d >= 0 || got_q.size() < 16) begin
         miscompares++;
         $display("FAIL redir_stream: n=%0d idx %0d got pc %h want pc %h",
                  got_q.size(), d, got_at(d).pc, exp_at(d).pc);
      end
   endtask

   task automatic test_error();
      int d;
      zero_addr = '1; err_beat = 64'h1008;
      set_knobs(60, 60, 60);
      do_reset(64'h1000);
      run(150);
      build_exp(64'h1000, 100);
      d = first_diff();
      vectors++;
      if (d >= 0 || got_q.size() != 4 || got_at(3).err !== 1'b1 || got_at(1).err !== 1'b0) begin
         miscompares++;
         $display("FAIL error_stream: n=%0d idx %0d got pc %h err %b want pc %h err %b",
                  got_q.size(), d, got_at(d).pc, got_at(d).err, exp_at(d).pc, exp_at(d).err);
      end
      vectors++;
      if (halted !== 1'b1 || ar_log.size() != 1 || beats_acc != 8) begin
         miscompares++;
         $display("FAIL error_state: halted %b ars %0d beats %0d want 1 1 8",
                  halted, ar_log.size(), beats_acc);
      end
   endtask

   task automatic test_random();
      logic [63:0] pc, line;
      int d, mode;
      bit ok;
      for (int it = 0; it < 6; it++) begin
         pc   = (it == 0) ? 64'hFFFF_FFFF_FFFF_FFC8 : {32'h0, $urandom} & ~64'h3;
         mode = $urandom_range(2);
         salt = $urandom;
         zero_addr = (mode == 1) ? pc + 64'(4 * $urandom_range(2, 40)) : '1;
         err_beat  = (mode == 2) ? (pc & ~64'h7) + 64'(8 * $urandom_range(0, 15)) : '1;
         set_knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100));
         do_reset(pc);
         run(300);
         build_exp(pc, 400);
         d = first_diff();
         vectors++;
         if (d >= 0 || (mode != 0 && got_q.size() != exp_q.size()) ||
             (mode == 0 && got_q.size() < 10)) begin
            miscompares++;
            $display("FAIL rand%0d_stream: mode %0d n=%0d/%0d idx %0d got pc %h want pc %h",
                     it, mode, got_q.size(), exp_q.size(), d, got_at(d).pc, exp_at(d).pc);
         end
         line = pc & ~64'h3F;
         ok = (ar_log.size() != 0);
         foreach (ar_log[i]) if (ar_log[i] !== line + 64'(i) * 64'h40) ok = 1'b0;
         vectors++;
         if (!ok || halted !== (mode != 0)) begin
            miscompares++;
            $display("FAIL rand%0d_ar: ars %0d first %h want %h, halted %b mode %0d",
                     it, ar_log.size(), ar_at(0), line, halted, mode);
         end
      end
   endtask

   initial begin
      reset = 1'b1; entry = '0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
      m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
      test_reset();
      test_linear();
      test_mid_line();
      test_backpressure();
      test_halt();
      test_redirect();
      test_error();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
